// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 32-bit core port in front of a 128-bit line memory.
// A miss writes back a dirty victim, refills the line, then replays the access through LOOKUP as a hit.
module l1_dcache_wb #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         core_req,
  output logic         core_gnt,
  input  logic         core_we,
  input  logic [31:0]  core_addr,
  input  logic [31:0]  core_wdata,
  input  logic [3:0]   core_be,
  output logic         core_rvalid,
  output logic [31:0]  core_rdata,
  output logic         mem_req,
  input  logic         mem_gnt,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  output logic [15:0]  mem_wstrb,
  input  logic [127:0] mem_rdata,
  input  logic         mem_rvalid
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_DONE, S_FILL_REQ, S_FILL_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 issued_q, issued_d;
  logic                 req_we_q;
  logic [31:2]          req_addr_q;
  logic [31:0]          req_wdata_q;
  logic [3:0]           req_be_q;
  logic [31:0]          rdata_q;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [127:0]         data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_word;
  logic [127:0]     cur_line, merged_line;
  logic [31:0]      cur_word;
  logic             hit, store_hit, fill, wb_done;
  logic             unused_addr_bits;

  assign req_idx          = req_addr_q[4 +: IDX_W];
  assign req_tag          = req_addr_q[31 -: TAG_W];
  assign req_word         = req_addr_q[3:2];
  assign cur_line         = data_q[req_idx];
  assign cur_word         = cur_line[{req_word, 5'd0} +: 32];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^core_addr[1:0];

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    merged_line = cur_line;
    for (int b = 0; b < 4; b++) begin
      if (req_be_q[b]) merged_line[{req_word, 5'd0} + 7'(b * 8) +: 8] = req_wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    core_gnt    = 1'b0;
    core_rvalid = 1'b0;
    core_rdata  = rdata_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    store_hit   = 1'b0;
    fill        = 1'b0;
    wb_done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        core_gnt = core_req;
        if (core_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        issued_d = 1'b0;
        if (hit) begin
          core_rvalid = 1'b1;
          core_rdata  = req_we_q ? 32'h0 : cur_word;
          store_hit   = req_we_q;
          state_d     = S_IDLE;
        end else if (dirty_q[req_idx]) begin
          state_d = S_WB_REQ;
        end else begin
          state_d = S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        // A request is only raised once the grant of the previous one has drained.
        mem_req   = issued_q || !mem_gnt;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, 4'h0};
        mem_wdata = cur_line;
        mem_wstrb = 16'hFFFF;
        if (issued_q && mem_gnt) begin
          issued_d = 1'b0;
          state_d  = S_WB_DONE;
        end else begin
          issued_d = mem_req;
        end
      end
      S_WB_DONE: begin
        wb_done = 1'b1;
        state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        mem_req  = issued_q || !mem_gnt;
        mem_addr = {req_tag, req_idx, 4'h0};
        if (issued_q && mem_gnt) begin
          issued_d = 1'b0;
          state_d  = S_FILL_WAIT;
        end else begin
          issued_d = mem_req;
        end
      end
      S_FILL_WAIT: begin
        if (mem_rvalid) begin
          fill    = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q     <= S_IDLE;
      issued_q    <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      rdata_q     <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      if (core_gnt) begin
        req_we_q    <= core_we;
        req_addr_q  <= core_addr[31:2];
        req_wdata_q <= core_wdata;
        req_be_q    <= core_be;
      end
      if (core_rvalid) rdata_q <= core_rdata;
      if (fill) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (store_hit) dirty_q[req_idx] <= 1'b1;
      if (wb_done)   dirty_q[req_idx] <= 1'b0;
    end
  end

  // NOTE: line data and tags are not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[req_idx] <= mem_rdata;
      tag_q[req_idx]  <= req_tag;
    end else if (store_hit) begin
      data_q[req_idx] <= merged_line;
    end
  end
endmodule

// File: tb/tb_l1_dcache_wb.sv
// Directed bench for l1_dcache_wb: a vector table of core accesses against a registered-grant line memory,
// plus a hand-written reset-during-refill sequence.
module tb_l1_dcache_wb;
  logic         clk_i, rst, mem_clear;
  logic         core_req, core_gnt, core_we, core_rvalid;
  logic [31:0]  core_addr, core_wdata, core_rdata;
  logic [3:0]   core_be;
  logic         mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  l1_dcache_wb #(.NUM_LINES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Untouched memory line n holds word w = {n, w, n, w} (one byte each).
  function automatic logic [127:0] line_pat(input logic [5:0] n);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = {2'b00, n, 8'(w), 2'b00, n, 8'(w)};
    return l;
  endfunction

  // Line memory: grant is a registered copy of mem_req, read data arrives the cycle after the handshake.
  logic [127:0] mem_w [64];
  logic [63:0]  mem_wv;
  logic         prev_req, prev_we;
  logic [31:0]  prev_addr, last_wb_addr;
  logic [127:0] prev_wdata, last_wb_data;
  logic [15:0]  last_wb_strb;
  int           wr_cnt, rd_cnt, viol_cnt, unstable_cnt;
  int           rv_cnt = 0;

  always @(posedge clk_i or posedge rst) begin
    if (rst) begin
      mem_gnt    <= 1'b0;
      mem_rvalid <= 1'b0;
      prev_req   <= 1'b0;
      if (mem_clear) begin
        mem_wv       <= '0;
        wr_cnt       <= 0;
        rd_cnt       <= 0;
        viol_cnt     <= 0;
        unstable_cnt <= 0;
      end
    end else begin
      mem_gnt    <= mem_req;
      mem_rvalid <= 1'b0;
      prev_req   <= mem_req;
      prev_we    <= mem_we;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
      if (mem_req && !prev_req && mem_gnt) viol_cnt <= viol_cnt + 1;
      if (mem_req && prev_req && (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
        unstable_cnt <= unstable_cnt + 1;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          wr_cnt                <= wr_cnt + 1;
          last_wb_addr          <= mem_addr;
          last_wb_data          <= mem_wdata;
          last_wb_strb          <= mem_wstrb;
          mem_w[mem_addr[9:4]]  <= mem_wdata;
          mem_wv[mem_addr[9:4]] <= 1'b1;
        end else begin
          rd_cnt     <= rd_cnt + 1;
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem_wv[mem_addr[9:4]] ? mem_w[mem_addr[9:4]] : line_pat(mem_addr[9:4]);
        end
      end
    end
  end

  always @(posedge clk_i) if (core_rvalid) rv_cnt <= rv_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  // Cycle 0 is the core_gnt cycle; samples are taken 2 time units after each rising edge.
  task automatic do_access(input vec_t v, output logic g0, output int lat, output logic [31:0] rd,
                           output logic rv_after, output logic [31:0] rd_after);
    @(posedge clk_i); #1;
    core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata; core_be = v.be;
    #1 g0 = core_gnt;
    @(posedge clk_i); #1;
    core_req = 1'b0;
    #1;
    lat = -1; rd = '0; rv_after = 1'b1; rd_after = '0;
    for (int c = 1; c <= 40; c++) begin
      if (core_rvalid) begin
        lat = c;
        rd  = core_rdata;
        break;
      end
      @(posedge clk_i); #2;
    end
    if (lat > 0) begin
      @(posedge clk_i); #2;
      rv_after = core_rvalid;
      rd_after = core_rdata;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic g0, rv_after;
    logic [31:0] rd, rd_after;
    int lat, wr0, rd0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    do_access(v, g0, lat, rd, rv_after, rd_after);
    check({tag, "_gnt"},       128'(g0),          128'(1'b1));
    check({tag, "_latency"},   128'(lat),         128'(v.exp_lat));
    check({tag, "_rdata"},     128'(rd),          128'(v.exp_rdata));
    check({tag, "_mem_wr"},    128'(wr_cnt - wr0), 128'(v.exp_wr));
    check({tag, "_mem_rd"},    128'(rd_cnt - rd0), 128'(v.exp_rd));
    check({tag, "_rv_pulse"},  128'(rv_after),    128'(1'b0));
    check({tag, "_rdata_hold"}, 128'(rd_after),   128'(v.exp_rdata));
  endtask

  vec_t vecs[11];

  initial begin
    int rv_before;
    vecs[0]  = '{we:1'b0, addr:32'h100, wdata:32'h0,        be:4'h0, exp_rdata:32'h10001000, exp_lat:5, exp_wr:0, exp_rd:1};
    vecs[1]  = '{we:1'b0, addr:32'h108, wdata:32'h0,        be:4'h0, exp_rdata:32'h10021002, exp_lat:1, exp_wr:0, exp_rd:0};
    vecs[2]  = '{we:1'b1, addr:32'h104, wdata:32'hDEADBEEF, be:4'hF, exp_rdata:32'h0,        exp_lat:1, exp_wr:0, exp_rd:0};
    vecs[3]  = '{we:1'b0, addr:32'h104, wdata:32'h0,        be:4'h0, exp_rdata:32'hDEADBEEF, exp_lat:1, exp_wr:0, exp_rd:0};
    vecs[4]  = '{we:1'b1, addr:32'h104, wdata:32'h000000AA, be:4'h1, exp_rdata:32'h0,        exp_lat:1, exp_wr:0, exp_rd:0};
    vecs[5]  = '{we:1'b0, addr:32'h104, wdata:32'h0,        be:4'h0, exp_rdata:32'hDEADBEAA, exp_lat:1, exp_wr:0, exp_rd:0};
    vecs[6]  = '{we:1'b0, addr:32'h204, wdata:32'h0,        be:4'h0, exp_rdata:32'h20012001, exp_lat:8, exp_wr:1, exp_rd:1};
    vecs[7]  = '{we:1'b0, addr:32'h104, wdata:32'h0,        be:4'h0, exp_rdata:32'hDEADBEAA, exp_lat:5, exp_wr:0, exp_rd:1};
    vecs[8]  = '{we:1'b1, addr:32'h30C, wdata:32'h12345678, be:4'hC, exp_rdata:32'h0,        exp_lat:5, exp_wr:0, exp_rd:1};
    vecs[9]  = '{we:1'b0, addr:32'h30C, wdata:32'h0,        be:4'h0, exp_rdata:32'h12343003, exp_lat:1, exp_wr:0, exp_rd:0};
    vecs[10] = '{we:1'b0, addr:32'h100, wdata:32'h0,        be:4'h0, exp_rdata:32'h10001000, exp_lat:8, exp_wr:1, exp_rd:1};

    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
    mem_clear = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    check("reset_core_gnt",    128'(core_gnt),    128'(1'b0));
    check("reset_core_rvalid", 128'(core_rvalid), 128'(1'b0));
    check("reset_core_rdata",  128'(core_rdata),  128'(32'h0));
    check("reset_mem_req",     128'(mem_req),     128'(1'b0));
    check("reset_mem_addr",    128'(mem_addr),    128'(32'h0));
    check("reset_mem_wstrb",   128'(mem_wstrb),   128'(16'h0));
    @(negedge clk_i);
    rst = 1'b0;
    mem_clear = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      if (i == 6) begin
        check("wb1_addr",  128'(last_wb_addr), 128'(32'h100));
        check("wb1_wstrb", 128'(last_wb_strb), 128'(16'hFFFF));
        check("wb1_wdata", last_wb_data, 128'h10031003_10021002_DEADBEAA_10001000);
      end
      if (i == 10) begin
        check("wb2_addr",  128'(last_wb_addr), 128'(32'h300));
        check("wb2_wdata", last_wb_data, 128'h12343003_30023002_30013001_30003000);
      end
    end

    // Reset while the refill of 0x150 sits in FILL_WAIT (cycle 4 of a clean miss).
    rv_before = rv_cnt;
    @(posedge clk_i); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h150; core_be = 4'h0;
    @(posedge clk_i); #1;
    core_req = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_fill_data_arriving", 128'(mem_rvalid), 128'(1'b1));
    rst = 1'b1;
    #1;
    check("rst_mem_req_now",     128'(mem_req),     128'(1'b0));
    check("rst_core_rvalid_now", 128'(core_rvalid), 128'(1'b0));
    check("rst_core_rdata_now",  128'(core_rdata),  128'(32'h0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
    check("rst_no_response", 128'(rv_cnt - rv_before), 128'(0));
    run_vec('{we:1'b0, addr:32'h108, wdata:32'h0, be:4'h0, exp_rdata:32'h10021002, exp_lat:5, exp_wr:0, exp_rd:1},
            "post_rst_invalid");
    run_vec('{we:1'b0, addr:32'h150, wdata:32'h0, be:4'h0, exp_rdata:32'h15001500, exp_lat:5, exp_wr:0, exp_rd:1},
            "post_rst_replay");

    check("mem_req_raised_under_gnt", 128'(viol_cnt),     128'(0));
    check("mem_outputs_unstable",     128'(unstable_cnt), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
